// File: rtl/water_flow_supervisor.sv
// Fill/drain/hold water-level watchdog with sticky coded error and explicit clear.
// Optional build macro LEVEL_FILTER_EN averages consecutive sensor samples before all checks.
module water_flow_supervisor #(
  parameter int unsigned LEVEL_W    = 10,
  parameter int unsigned THRESHOLD  = 10,
  parameter int unsigned TIME_LIMIT = 5,
  parameter int unsigned MAX_LEVEL  = 1000,
  localparam int unsigned CNT_W     = $clog2(TIME_LIMIT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] water_level_sensor,
  input  logic [1:0]         mode,
  input  logic               error_clear,
  output logic               error_flag,
  output logic [2:0]         error_code,
  output logic               progress,
  output logic [CNT_W-1:0]   stall_count
);

  localparam logic [1:0] ModeIdle  = 2'b00;
  localparam logic [1:0] ModeFill  = 2'b01;
  localparam logic [1:0] ModeDrain = 2'b10;
  localparam logic [1:0] ModeHold  = 2'b11;

  localparam logic [LEVEL_W:0] Thr    = (LEVEL_W + 1)'(THRESHOLD);
  localparam logic [LEVEL_W:0] MaxLvl = (LEVEL_W + 1)'(MAX_LEVEL);
  localparam logic [LEVEL_W:0] FullSc = {1'b0, {LEVEL_W{1'b1}}};
  localparam logic [CNT_W-1:0] TLim   = CNT_W'(TIME_LIMIT);

  typedef enum logic [1:0] {StIdle, StMonitor, StError} state_e;

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] baseline_q, baseline_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flag_q, flag_d;
  logic [2:0]         code_q, code_d;
  logic               prog_q, prog_d;

  logic [LEVEL_W-1:0] level;

`ifdef LEVEL_FILTER_EN
  logic [LEVEL_W-1:0] s_prev;
  logic [LEVEL_W:0]   filt_sum;

  always_ff @(posedge clk) begin
    if (reset) s_prev <= water_level_sensor;
    else       s_prev <= water_level_sensor;
  end

  // Two-sample average rejects single-cycle spikes.
  assign filt_sum = {1'b0, water_level_sensor} + {1'b0, s_prev};
  assign level    = filt_sum[LEVEL_W:1];
`else
  assign level = water_level_sensor;
`endif

  // All arithmetic is one bit wider than the level so nothing wraps.
  logic [LEVEL_W:0] level_x, base_x, add_raw, up_lim, dn_lim, dev;
  logic             overflow, fill_prog, drain_prog, hold_viol, mode_chg, stall, timeout;

  always_comb begin
    level_x = {1'b0, level};
    base_x  = {1'b0, baseline_q};
    add_raw = base_x + Thr;
    up_lim  = (add_raw > FullSc) ? FullSc : add_raw;
    dn_lim  = (base_x >= Thr) ? (base_x - Thr) : '0;
    dev     = (level_x >= base_x) ? (level_x - base_x) : (base_x - level_x);

    overflow   = level_x >= MaxLvl;
    fill_prog  = level_x > up_lim;
    drain_prog = level_x < dn_lim;
    hold_viol  = dev > Thr;
    mode_chg   = mode != mode_q;

    stall = (mode != ModeIdle) && !mode_chg &&
            (((mode_q == ModeFill) && !fill_prog) ||
             ((mode_q == ModeDrain) && !drain_prog) ||
             ((mode_q == ModeHold) && hold_viol));
    timeout = stall && (cnt_q >= TLim);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (mode != ModeIdle) state_d = StMonitor;
      StMonitor: begin
        if (overflow || timeout)    state_d = StError;
        else if (mode == ModeIdle)  state_d = StIdle;
      end
      StError:   if (error_clear) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    baseline_d = baseline_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    flag_d     = flag_q;
    code_d     = code_q;
    prog_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        baseline_d = level;
        cnt_d      = '0;
        if (mode != ModeIdle) mode_d = mode;
      end
      StMonitor: begin
        if (overflow) begin
          flag_d = 1'b1;
          code_d = 3'd4;
        end else if (mode == ModeIdle) begin
          // Leave; IDLE reloads baseline and counter.
        end else if (mode_chg) begin
          baseline_d = level;
          cnt_d      = '0;
          mode_d     = mode;
        end else if (stall) begin
          if (timeout) begin
            flag_d = 1'b1;
            unique case (mode_q)
              ModeFill:  code_d = 3'd1;
              ModeDrain: code_d = 3'd2;
              default:   code_d = 3'd3;
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (mode_q == ModeHold) begin
          cnt_d = '0;
        end else begin
          baseline_d = level;
          cnt_d      = '0;
          prog_d     = 1'b1;
        end
      end
      StError: begin
        if (error_clear) begin
          flag_d     = 1'b0;
          code_d     = 3'd0;
          cnt_d      = '0;
          baseline_d = level;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baseline_q <= water_level_sensor;
      mode_q     <= ModeIdle;
      cnt_q      <= '0;
      flag_q     <= 1'b0;
      code_q     <= 3'd0;
      prog_q     <= 1'b0;
    end else begin
      baseline_q <= baseline_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      flag_q     <= flag_d;
      code_q     <= code_d;
      prog_q     <= prog_d;
    end
  end

  assign error_flag  = flag_q;
  assign error_code  = code_q;
  assign progress    = prog_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_water_flow_supervisor.sv
// Directed bench for water_flow_supervisor with default parameters (THRESHOLD 10, TIME_LIMIT 5,
// MAX_LEVEL 1000).
module tb_water_flow_supervisor;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] water_level_sensor;
  logic [1:0] mode;
  logic       error_clear;
  logic       error_flag;
  logic [2:0] error_code;
  logic       progress;
  logic [2:0] stall_count;

  int checks   = 0;
  int failures = 0;

  water_flow_supervisor dut (
    .clk                (clk),
    .reset              (reset),
    .water_level_sensor (water_level_sensor),
    .mode               (mode),
    .error_clear        (error_clear),
    .error_flag         (error_flag),
    .error_code         (error_code),
    .progress           (progress),
    .stall_count        (stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic f, input logic [2:0] c,
                           input logic p, input logic [2:0] n);
    check({tag, ".flag"}, 32'(error_flag), 32'(f));
    check({tag, ".code"}, 32'(error_code), 32'(c));
    check({tag, ".prog"}, 32'(progress), 32'(p));
    check({tag, ".cnt"}, 32'(stall_count), 32'(n));
  endtask

  task automatic do_reset(input logic [9:0] lvl);
    reset = 1'b1; mode = 2'b00; error_clear = 1'b0; water_level_sensor = lvl;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mode = 2'b00; error_clear = 1'b0; water_level_sensor = 10'd100;
    tick(); tick();
    check_all("reset", 1'b0, 3'd0, 1'b0, 3'd0);

    // Fill progress 100 -> 111 -> 122.
    reset = 1'b0; mode = 2'b01;
    tick();
    check_all("fill_entry", 1'b0, 3'd0, 1'b0, 3'd0);
    water_level_sensor = 10'd111; tick();
    check_all("fill_step1", 1'b0, 3'd0, 1'b1, 3'd0);
    water_level_sensor = 10'd122; tick();
    check_all("fill_step2", 1'b0, 3'd0, 1'b1, 3'd0);
    water_level_sensor = 10'd132; tick();
    check_all("fill_small_step", 1'b0, 3'd0, 1'b0, 3'd1);

    // Fill timeout at constant level.
    do_reset(10'd100);
    mode = 2'b01; tick();
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("fill_to.cnt", 32'(stall_count), 32'(i));
      check("fill_to.flag", 32'(error_flag), 32'd0);
    end
    tick();
    check_all("fill_to_err", 1'b1, 3'd1, 1'b0, 3'd5);
    water_level_sensor = 10'd200; mode = 2'b10; tick();
    check_all("err_sticky", 1'b1, 3'd1, 1'b0, 3'd5);

    // Clear, then drain saturation from baseline 5 to level 0.
    error_clear = 1'b1; mode = 2'b00; water_level_sensor = 10'd5; tick();
    check_all("clear", 1'b0, 3'd0, 1'b0, 3'd0);
    error_clear = 1'b0; tick();
    mode = 2'b10; tick();
    water_level_sensor = 10'd0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("drain_sat.cnt", 32'(stall_count), 32'(i));
      check("drain_sat.prog", 32'(progress), 32'd0);
    end
    tick();
    check_all("drain_sat_err", 1'b1, 3'd2, 1'b0, 3'd5);

    // Reset while in ERROR.
    reset = 1'b1; tick();
    check_all("reset_in_err", 1'b0, 3'd0, 1'b0, 3'd0);

    // Hold leak and recovery around baseline 500.
    do_reset(10'd500);
    mode = 2'b11; tick();
    water_level_sensor = 10'd515;
    tick(); tick(); tick();
    check_all("hold_leak3", 1'b0, 3'd0, 1'b0, 3'd3);
    water_level_sensor = 10'd505; tick();
    check_all("hold_recover", 1'b0, 3'd0, 1'b0, 3'd0);
    water_level_sensor = 10'd515; tick();
    check("hold_again.cnt", 32'(stall_count), 32'd1);
    water_level_sensor = 10'd490; tick();
    check_all("hold_band_edge", 1'b0, 3'd0, 1'b0, 3'd0);
    water_level_sensor = 10'd515;
    for (int i = 1; i <= 5; i++) tick();
    check("hold_sustain.cnt", 32'(stall_count), 32'd5);
    tick();
    check_all("hold_err", 1'b1, 3'd3, 1'b0, 3'd5);

    // Overflow boundary, clear, drain re-entry with fresh baseline.
    do_reset(10'd100);
    mode = 2'b01; tick();
    water_level_sensor = 10'd999; tick();
    check_all("below_max", 1'b0, 3'd0, 1'b1, 3'd0);
    water_level_sensor = 10'd1000; tick();
    check_all("overflow", 1'b1, 3'd4, 1'b0, 3'd0);
    error_clear = 1'b1; mode = 2'b00; water_level_sensor = 10'd300; tick();
    check_all("ovf_clear", 1'b0, 3'd0, 1'b0, 3'd0);
    error_clear = 1'b0; mode = 2'b10; tick();
    water_level_sensor = 10'd289; tick();
    check_all("drain_rebase", 1'b0, 3'd0, 1'b1, 3'd0);

    // Mode switch at counter 4 reloads baseline and clears the counter.
    do_reset(10'd100);
    mode = 2'b01; tick();
    tick(); tick(); tick(); tick();
    check("pre_switch.cnt", 32'(stall_count), 32'd4);
    mode = 2'b10; water_level_sensor = 10'd150; tick();
    check_all("switch", 1'b0, 3'd0, 1'b0, 3'd0);
    water_level_sensor = 10'd139; tick();
    check_all("switch_rebase", 1'b0, 3'd0, 1'b1, 3'd0);

    // Overflow wins over a simultaneous mode change.
    mode = 2'b11; water_level_sensor = 10'd1000; tick();
    check_all("ovf_on_switch", 1'b1, 3'd4, 1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
